// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger
//   Drives an HC-SR04-class ultrasonic sensor from a 1 MHz clock and reports
//   the measured distance in whole centimetres.
//
//   Each measurement period does the following:
//   1. Issue a trigger pulse.
//   2. Wait for the echo to rise.
//   3. Time the echo-high width.
//   4. Convert the width to centimetres: floor(width / US_PER_CM).
//   5. Publish the result with a one-cycle valid strobe.
//   A distance of 0 means "no valid reading".
//
// Ports
//   clk          in   1 MHz system clock (1 cycle = 1 us)
//   rst_n        in   asynchronous active-low reset
//   en           in   measurement enable, sampled when a period starts
//   echo         in   raw sensor echo (asynchronous, synchronised here)
//   trig         out  sensor trigger pulse, TRIG_US cycles wide
//   distance_cm  out  last result, held between updates; 0 = invalid
//   valid        out  one-cycle strobe when distance_cm/timeout update
//   timeout      out  1 when the last measurement ended invalid
//
// Output strobe semantics
//   valid is a pure strobe with no back-pressure. distance_cm and timeout
//   change only on the same clock edge that raises valid, and they hold
//   their values until the next strobe.
//
// Build option
//   MEDIAN3_EN  When defined, distance_cm reports the median of the last
//               three valid readings. Until three valid readings exist, the
//               raw reading is reported instead. This option adds one cycle
//               of valid latency.

module ultrasonic_ranger #(
  parameter int TRIG_US    = 10,
  parameter int PERIOD_US  = 60000,
  parameter int TIMEOUT_US = 30000,
  parameter int US_PER_CM  = 58,
  parameter int MAX_CM     = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] distance_cm,
  output logic        valid,
  output logic        timeout
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIG    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_MEASURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_HOLDOFF = 3'd5;

  localparam int PCW = $clog2(PERIOD_US + 1);
  localparam int TRW = $clog2(TRIG_US + 1);
  localparam int TOW = $clog2(TIMEOUT_US + 1);
  localparam int SCW = $clog2(US_PER_CM + 1);

  // ---------------------------------------------------------------------
  // Echo synchroniser and edge detection
  // ---------------------------------------------------------------------
  logic echo_s1_q, echo_s2_q, echo_prev_q;
  logic echo_rise, echo_fall;

  assign echo_rise = echo_s2_q & ~echo_prev_q;
  assign echo_fall = ~echo_s2_q & echo_prev_q;

  // ---------------------------------------------------------------------
  // FSM and counters
  // ---------------------------------------------------------------------
  logic [2:0]     state_q, state_d;
  logic [PCW-1:0] period_cnt_q, period_cnt_d;
  logic [TRW-1:0] trig_cnt_q, trig_cnt_d;
  logic [TOW-1:0] wait_cnt_q, wait_cnt_d;
  logic [TOW-1:0] hi_cnt_q, hi_cnt_d;
  logic [SCW-1:0] sub_cnt_q, sub_cnt_d;
  logic [15:0]    cm_cnt_q, cm_cnt_d;
  logic [15:0]    result_q, result_d;
  logic           err_q, err_d;
  logic           trig_q, trig_d;

  logic           period_start;
  logic           cm_wrap;
  logic [SCW-1:0] sub_next;
  logic [15:0]    cm_next;

  // The period counter is parked at zero in IDLE. Leaving IDLE therefore
  // starts a fresh period aligned with the first trigger cycle.
  assign period_start = (state_q != ST_IDLE) &&
                        (period_cnt_q == PCW'(PERIOD_US - 1));

  always_comb begin
    period_cnt_d = period_cnt_q + PCW'(1);
    if (state_q == ST_IDLE || period_start) begin
      period_cnt_d = '0;
    end
  end

  // Every MEASURE cycle counts one echo-high cycle, including the cycle in
  // which the falling edge is seen. The rising-edge cycle itself was spent
  // in WAIT_RISE, so the total number of increments equals the echo width.
  assign cm_wrap  = (sub_cnt_q == SCW'(US_PER_CM - 1));
  assign sub_next = cm_wrap ? '0 : sub_cnt_q + SCW'(1);
  assign cm_next  = (cm_wrap && cm_cnt_q != 16'hFFFF) ? cm_cnt_q + 16'd1
                                                      : cm_cnt_q;

  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    wait_cnt_d = wait_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    sub_cnt_d  = sub_cnt_q;
    cm_cnt_d   = cm_cnt_q;
    result_d   = result_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d    = ST_TRIG;
          trig_cnt_d = '0;
        end
      end

      ST_TRIG: begin
        if (trig_cnt_q == TRW'(TRIG_US - 1)) begin
          state_d    = ST_WAIT;
          trig_cnt_d = '0;
          wait_cnt_d = '0;
        end else begin
          trig_cnt_d = trig_cnt_q + TRW'(1);
        end
      end

      // An echo that is already high on entry produces no rising edge here.
      // Such a cycle therefore ends in a timeout.
      ST_WAIT: begin
        if (echo_rise) begin
          state_d   = ST_MEASURE;
          sub_cnt_d = '0;
          cm_cnt_d  = '0;
          hi_cnt_d  = '0;
        end else if (wait_cnt_q == TOW'(TIMEOUT_US - 1)) begin
          state_d  = ST_DONE;
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TOW'(1);
        end
      end

      ST_MEASURE: begin
        sub_cnt_d = sub_next;
        cm_cnt_d  = cm_next;
        if (echo_fall) begin
          state_d = ST_DONE;
          if (cm_next > 16'(MAX_CM)) begin
            result_d = '0;
            err_d    = 1'b1;
          end else begin
            result_d = cm_next;
            err_d    = 1'b0;
          end
        end else if (hi_cnt_q == TOW'(TIMEOUT_US - 1)) begin
          state_d  = ST_DONE;
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          hi_cnt_d = hi_cnt_q + TOW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_HOLDOFF;
      end

      // A period start seen during WAIT_RISE/MEASURE is not remembered.
      // The next trigger waits for the following wrap.
      ST_HOLDOFF: begin
        if (period_start) begin
          state_d    = en ? ST_TRIG : ST_IDLE;
          trig_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // trig is registered from the next state so the sensor pin never sees
  // a decode glitch.
  assign trig_d = (state_d == ST_TRIG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1_q    <= 1'b0;
      echo_s2_q    <= 1'b0;
      echo_prev_q  <= 1'b0;
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      trig_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      hi_cnt_q     <= '0;
      sub_cnt_q    <= '0;
      cm_cnt_q     <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      trig_q       <= 1'b0;
    end else begin
      echo_s1_q    <= echo;
      echo_s2_q    <= echo_s1_q;
      echo_prev_q  <= echo_s2_q;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      trig_cnt_q   <= trig_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      sub_cnt_q    <= sub_cnt_d;
      cm_cnt_q     <= cm_cnt_d;
      result_q     <= result_d;
      err_q        <= err_d;
      trig_q       <= trig_d;
    end
  end

  // ---------------------------------------------------------------------
  // Result publication
  // ---------------------------------------------------------------------
  logic [15:0] distance_q;
  logic        valid_q;
  logic        timeout_q;

`ifdef MEDIAN3_EN
  logic [15:0] hist0_q, hist1_q, hist2_q;
  logic [1:0]  hist_cnt_q;
  logic        pend_q;
  logic        pend_err_q;

  function automatic logic [15:0] med3(input logic [15:0] a,
                                       input logic [15:0] b,
                                       input logic [15:0] c);
    logic [15:0] m;
    if ((a >= b && a <= c) || (a <= b && a >= c)) begin
      m = a;
    end else if ((b >= a && b <= c) || (b <= a && b >= c)) begin
      m = b;
    end else begin
      m = c;
    end
    return m;
  endfunction

  // DONE loads the history and raises pend_q. The following cycle
  // registers the median, so valid comes one cycle later than in the
  // raw build. Error results bypass the history but still report 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0_q    <= '0;
      hist1_q    <= '0;
      hist2_q    <= '0;
      hist_cnt_q <= '0;
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
      distance_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      pend_q  <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        pend_err_q <= err_q;
        if (!err_q) begin
          hist2_q <= hist1_q;
          hist1_q <= hist0_q;
          hist0_q <= result_q;
          if (hist_cnt_q != 2'd3) begin
            hist_cnt_q <= hist_cnt_q + 2'd1;
          end
        end
      end
      if (pend_q) begin
        valid_q <= 1'b1;
        if (pend_err_q) begin
          distance_q <= '0;
          timeout_q  <= 1'b1;
        end else begin
          distance_q <= (hist_cnt_q == 2'd3) ? med3(hist0_q, hist1_q, hist2_q)
                                             : hist0_q;
          timeout_q  <= 1'b0;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      distance_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      valid_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        distance_q <= result_q;
        timeout_q  <= err_q;
      end
    end
  end
`endif

  assign trig        = trig_q;
  assign distance_cm = distance_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger
//   Directed bench for ultrasonic_ranger. It uses a shortened period and
//   timeout so the whole run stays short. US_PER_CM stays at 58, so the
//   centimetre values match the hand-computed table.

module tb_ultrasonic_ranger;

  localparam int P_TRIG    = 10;
  localparam int P_PERIOD  = 6200;
  localparam int P_TIMEOUT = 6000;
  localparam int P_UPC     = 58;
  localparam int P_MAX     = 100;

`ifdef MEDIAN3_EN
  localparam int EXP_LAT = 5;
`else
  localparam int EXP_LAT = 4;
`endif
  // From trig falling to valid when the echo never rises.
  localparam int EXP_TO_LAT = P_TIMEOUT + EXP_LAT - 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        echo;
  logic        trig;
  logic [15:0] distance_cm;
  logic        valid;
  logic        timeout;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];

  ultrasonic_ranger #(
    .TRIG_US   (P_TRIG),
    .PERIOD_US (P_PERIOD),
    .TIMEOUT_US(P_TIMEOUT),
    .US_PER_CM (P_UPC),
    .MAX_CM    (P_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .echo       (echo),
    .trig       (trig),
    .distance_cm(distance_cm),
    .valid      (valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: got time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_trig_rise(output int t);
    int n;
    n = 0;
    while (trig !== 1'b1 && n < P_PERIOD + 200) begin
      step(1);
      n++;
    end
    check_eq("trig_rise", {31'd0, trig}, 32'd1);
    t = cyc;
  endtask

  task automatic wait_trig_fall(output int w);
    w = 0;
    while (trig === 1'b1 && w < 100) begin
      step(1);
      w++;
    end
  endtask

  task automatic drive_echo(input int width);
    step(5);
    echo = 1'b1;
    step(width);
    echo = 1'b0;
  endtask

  task automatic wait_valid(output logic [15:0] d, output logic to,
                            output int lat);
    lat = 0;
    while (valid !== 1'b1 && lat < P_TIMEOUT + 200) begin
      step(1);
      lat++;
    end
    check_eq("valid_seen", {31'd0, valid}, 32'd1);
    d  = distance_cm;
    to = timeout;
    step(1);
    check_eq("valid_one_cycle", {31'd0, valid}, 32'd0);
  endtask

  task automatic measure(input string tag, input int width,
                         input logic [15:0] exp_d, input logic exp_to);
    int t, w, lat;
    logic [15:0] d;
    logic to;
    wait_trig_rise(t);
    wait_trig_fall(w);
    drive_echo(width);
    wait_valid(d, to, lat);
    check_eq(tag, {16'd0, d}, {16'd0, exp_d});
    check_eq({tag, "_to"}, {31'd0, to}, {31'd0, exp_to});
  endtask

  // ---------------- stimulus ----------------
  int widths[3] = '{1160, 5800, 1276};

  initial begin
    int t1, t2, w, lat, n;
    logic [15:0] d;
    logic to;
    logic [15:0] e;

    rst_n = 1'b0;
    en    = 1'b0;
    echo  = 1'b0;
    step(3);
    check_eq("rst_trig",    {31'd0, trig},    32'd0);
    check_eq("rst_dist",    {16'd0, distance_cm}, 32'd0);
    check_eq("rst_valid",   {31'd0, valid},   32'd0);
    check_eq("rst_timeout", {31'd0, timeout}, 32'd0);

    // 580 us echo -> 10 cm, trigger width and latency
    rst_n = 1'b1;
    en    = 1'b1;
    wait_trig_rise(t1);
    wait_trig_fall(w);
    check_eq("trig_width", w, P_TRIG);
    drive_echo(580);
    wait_valid(d, to, lat);
    check_eq("lat_580", lat, EXP_LAT);
    check_eq("d_580", {16'd0, d}, 32'd10);
    check_eq("d_580_to", {31'd0, to}, 32'd0);

    // next trigger exactly one period later; floor boundary 696/695
    wait_trig_rise(t2);
    check_eq("trig_period", t2 - t1, P_PERIOD);
    wait_trig_fall(w);
    drive_echo(696);
    wait_valid(d, to, lat);
    check_eq("d_696", {16'd0, d}, 32'd12);
    check_eq("d_696_to", {31'd0, to}, 32'd0);
    measure("d_695", 695, 16'd11, 1'b0);

    // en dropped in HOLDOFF: no further trigger
    en = 1'b0;
    n  = 0;
    repeat (P_PERIOD) begin
      step(1);
      if (trig === 1'b1) n++;
    end
    check_eq("no_trig_en0", n, 0);

    // echo never rises -> timeout after TIMEOUT_US cycles in WAIT_RISE
    en = 1'b1;
    wait_trig_rise(t1);
    wait_trig_fall(w);
    wait_valid(d, to, lat);
    check_eq("lat_norise", lat, EXP_TO_LAT);
    check_eq("d_norise", {16'd0, d}, 32'd0);
    check_eq("d_norise_to", {31'd0, to}, 32'd1);

    // shorter than one centimetre -> 0 without timeout; beyond MAX_CM
    measure("d_short", 40, 16'd0, 1'b0);
    measure("d_overmax", 5916, 16'd0, 1'b1);

    // 20, 100, 22 cm after a clean reset
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    exp_q.push_back(16'd20);
    exp_q.push_back(16'd100);
    exp_q.push_back(16'd22);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      measure($sformatf("d_seq%0d", i), widths[i], e, 1'b0);
    end

    // reset in the middle of MEASURE
    wait_trig_rise(t1);
    wait_trig_fall(w);
    step(5);
    echo = 1'b1;
    step(100);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_trig",    {31'd0, trig},    32'd0);
    check_eq("mid_rst_dist",    {16'd0, distance_cm}, 32'd0);
    check_eq("mid_rst_valid",   {31'd0, valid},   32'd0);
    check_eq("mid_rst_timeout", {31'd0, timeout}, 32'd0);
    en   = 1'b0;
    echo = 1'b0;
    step(5);
    rst_n = 1'b1;
    n = 0;
    repeat (50) begin
      step(1);
      if (valid === 1'b1 || trig === 1'b1) n++;
    end
    check_eq("post_rst_quiet", n, 0);

    // echo stuck high from before the trigger
    rst_n = 1'b0;
    echo  = 1'b1;
    step(2);
    rst_n = 1'b1;
    en    = 1'b1;
    wait_trig_rise(t1);
    wait_trig_fall(w);
    wait_valid(d, to, lat);
    check_eq("lat_stuck", lat, EXP_TO_LAT);
    check_eq("d_stuck", {16'd0, d}, 32'd0);
    check_eq("d_stuck_to", {31'd0, to}, 32'd1);
    echo = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
